// File: rtl/ahb_lite_master_arbiter.sv
// Two-master AHB-Lite arbiter: muxes one master's address phase onto the shared bus, routes HWDATA/HRESP by data-phase owner.
// Latency: zero; the grant and the address mux are combinational, and a switch lands in the owner's first IDLE cycle.
// Backpressure: the losing master's HREADY is held low while it presents NONSEQ; bus wait states freeze all state. Optional stats: ARB_STATS_EN.
module ahb_lite_master_arbiter #(
    parameter bit PARK_MASTER = 1'b0,
    parameter int CNT_W       = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [2:0]  M0_HBURST,
    input  logic [3:0]  M0_HPROT,
    input  logic        M0_HMASTLOCK,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HRESP,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [2:0]  M1_HBURST,
    input  logic [3:0]  M1_HPROT,
    input  logic        M1_HMASTLOCK,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HRESP,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP,
    output logic        HMASTER
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] STAT_GRANT0,
    output logic [CNT_W-1:0] STAT_GRANT1,
    output logic [CNT_W-1:0] STAT_STALL0,
    output logic [CNT_W-1:0] STAT_STALL1
`endif
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } ahb_addr_t;

    ahb_addr_t mst [2];
    ahb_addr_t sel;

    logic owner, data_valid, data_owner, lock_hold;
    logic g, other;
    logic m0_serve, m1_serve, stall0, stall1;

    assign mst[0] = '{M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK};
    assign mst[1] = '{M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK};
    assign other  = ~owner;

    // Grant: owner keeps the bus unless it is idle, unlocked, and the other master opens a NONSEQ.
    always_comb begin
        g = owner;
        if (!lock_hold && mst[owner].trans == TR_IDLE && mst[other].trans == TR_NONSEQ)
            g = other;
    end

    assign sel = mst[g];

    // Address phase goes straight through; reset forces an idle, unlocked bus.
    assign HADDR     = sel.addr;
    assign HWRITE    = sel.write;
    assign HSIZE     = sel.size;
    assign HBURST    = sel.burst;
    assign HPROT     = sel.prot;
    assign HTRANS    = HRESET ? TR_IDLE : sel.trans;
    assign HMASTLOCK = HRESET ? 1'b0 : sel.lock;
    assign HMASTER   = HRESET ? PARK_MASTER : g;

    // Data phase follows the registered data owner.
    assign HWDATA    = data_owner ? M1_HWDATA : M0_HWDATA;
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
    assign M0_HRESP  = !HRESET && data_valid && !data_owner && HRESP;
    assign M1_HRESP  = !HRESET && data_valid &&  data_owner && HRESP;

    // A master sees the bus ready when it owns either phase; otherwise a pending NONSEQ is stalled.
    assign m0_serve  = !g || (data_valid && !data_owner);
    assign m1_serve  =  g || (data_valid &&  data_owner);
    assign stall0    = !m0_serve && M0_HTRANS == TR_NONSEQ;
    assign stall1    = !m1_serve && M1_HTRANS == TR_NONSEQ;
    assign M0_HREADY = HRESET ? 1'b1 : (m0_serve ? HREADY : !stall0);
    assign M1_HREADY = HRESET ? 1'b1 : (m1_serve ? HREADY : !stall1);

    // Arbitration state advances only when the slave accepts the address phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            owner      <= PARK_MASTER;
            data_valid <= 1'b0;
            data_owner <= PARK_MASTER;
            lock_hold  <= 1'b0;
        end else if (HREADY) begin
            owner      <= g;
            data_valid <= sel.trans[1];
            data_owner <= g;
            lock_hold  <= sel.lock && (sel.trans != TR_IDLE);
        end
    end

`ifdef ARB_STATS_EN
    // Saturating grant/stall counters; stalls count arbitration holds only, never slave waits.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            STAT_GRANT0 <= '0;
            STAT_GRANT1 <= '0;
            STAT_STALL0 <= '0;
            STAT_STALL1 <= '0;
        end else begin
            if (HREADY && sel.trans[1] && !g && !(&STAT_GRANT0)) STAT_GRANT0 <= STAT_GRANT0 + CNT_W'(1);
            if (HREADY && sel.trans[1] &&  g && !(&STAT_GRANT1)) STAT_GRANT1 <= STAT_GRANT1 + CNT_W'(1);
            if (stall0 && !(&STAT_STALL0)) STAT_STALL0 <= STAT_STALL0 + CNT_W'(1);
            if (stall1 && !(&STAT_STALL1)) STAT_STALL1 <= STAT_STALL1 + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Directed bench for ahb_lite_master_arbiter: stimulus pushes expected field values, a monitor compares at negedge.
// Latency: expectations are for the cycle they are pushed in (combinational paths) or after the preceding edge.
// Backpressure: the bench plays the slave, driving HREADY/HRESP to insert waits and errors.
module tb_ahb_lite_master_arbiter;

    localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;

    typedef enum int {F_HADDR, F_HTRANS, F_HMASTER, F_R0, F_R1, F_E0, F_E1, F_HWDATA, F_RD0, F_LOCK, F_ST1} fld_t;
    typedef struct {
        string       name;
        fld_t        fld;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic        HCLK, HRESET;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
    logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
    logic [3:0]  M0_HPROT, M1_HPROT;
    logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP, HMASTER;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
`ifdef ARB_STATS_EN
    logic [15:0] STAT_GRANT0, STAT_GRANT1, STAT_STALL0, STAT_STALL1;
`endif

    ahb_lite_master_arbiter dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
        .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
        .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
        .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
        .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .HMASTER(HMASTER)
`ifdef ARB_STATS_EN
        ,
        .STAT_GRANT0(STAT_GRANT0), .STAT_GRANT1(STAT_GRANT1),
        .STAT_STALL0(STAT_STALL0), .STAT_STALL1(STAT_STALL1)
`endif
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation timed out");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] v);
        checks++;
        if (act !== v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, v);
        end
    endtask

    task automatic ex(input string nm, input fld_t f, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.fld  = f;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_m0(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic lk, input logic [31:0] wd);
        M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = wr; M0_HMASTLOCK = lk; M0_HWDATA = wd;
    endtask

    task automatic set_m1(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic lk, input logic [31:0] wd);
        M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = wr; M1_HMASTLOCK = lk; M1_HWDATA = wd;
    endtask

    // Monitor: every negedge, compare all expectations queued for this cycle.
    initial begin
        forever begin
            @(negedge HCLK);
            while (exp_q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = exp_q.pop_front();
                act = '0;
                case (e.fld)
                    F_HADDR:   act = HADDR;
                    F_HTRANS:  act = {30'd0, HTRANS};
                    F_HMASTER: act = {31'd0, HMASTER};
                    F_R0:      act = {31'd0, M0_HREADY};
                    F_R1:      act = {31'd0, M1_HREADY};
                    F_E0:      act = {31'd0, M0_HRESP};
                    F_E1:      act = {31'd0, M1_HRESP};
                    F_HWDATA:  act = HWDATA;
                    F_RD0:     act = M0_HRDATA;
                    F_LOCK:    act = {31'd0, HMASTLOCK};
`ifdef ARB_STATS_EN
                    F_ST1:     act = {16'd0, STAT_STALL1};
`endif
                    default:   act = 'x;
                endcase
                chk(e.name, act, e.val);
            end
        end
    end

    initial begin
        M0_HSIZE = 3'd2; M1_HSIZE = 3'd2; M0_HBURST = 3'd0; M1_HBURST = 3'd0;
        M0_HPROT = 4'h3; M1_HPROT = 4'h3;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        HRESET = 1'b1;
        set_m0(NONSEQ, 32'h0000_1234, 1'b0, 1'b1, 32'h0);
        set_m1(NONSEQ, 32'h5000_0000, 1'b0, 1'b0, 32'h0);
        #2;
        chk("rst_direct_htrans", {30'd0, HTRANS}, 32'(IDLE));
        // Reset gating: bus idle and unlocked, both masters ready, no errors.
        ex("rst_htrans", F_HTRANS, 32'(IDLE));
        ex("rst_lock", F_LOCK, 0);
        ex("rst_hmaster", F_HMASTER, 0);
        ex("rst_r0", F_R0, 1);
        ex("rst_r1", F_R1, 1);
        HRESP = 1'b1;
        ex("rst_e0", F_E0, 0);
        ex("rst_e1", F_E1, 0);
        step();
        HRESP = 1'b0;

        // Reset release, M0 single read.
        step();
        HRESET = 1'b0;
        set_m0(NONSEQ, 32'h2000_0000, 1'b0, 1'b0, 32'h0);
        set_m1(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        ex("rd_haddr", F_HADDR, 32'h2000_0000);
        ex("rd_hmaster", F_HMASTER, 0);
        ex("rd_htrans", F_HTRANS, 32'(NONSEQ));
        ex("rd_r1", F_R1, 1);
        step();
        set_m0(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        HRDATA = 32'hCAFE_0001;
        ex("rd_hrdata", F_RD0, 32'hCAFE_0001);
        ex("rd_e0", F_E0, 0);
        ex("rd_idle", F_HTRANS, 32'(IDLE));

        // M0 INCR4 write, M1 requests from beat 2 and waits for M0's IDLE.
        step();
        M0_HBURST = 3'd3;
        set_m0(NONSEQ, 32'h0000_1000, 1'b1, 1'b0, 32'h0);
        ex("wr_b1_haddr", F_HADDR, 32'h0000_1000);
        for (int b = 1; b < 4; b++) begin
            step();
            set_m0(SEQ, 32'h0000_1000 + 32'(4 * b), 1'b1, 1'b0, 32'hD000_0000 + 32'(b - 1));
            set_m1(NONSEQ, 32'h4000_0000, 1'b0, 1'b0, 32'h0);
            ex($sformatf("wr_b%0d_r1", b + 1), F_R1, 0);
            ex($sformatf("wr_b%0d_haddr", b + 1), F_HADDR, 32'h0000_1000 + 32'(4 * b));
            ex($sformatf("wr_b%0d_hwdata", b + 1), F_HWDATA, 32'hD000_0000 + 32'(b - 1));
            ex($sformatf("wr_b%0d_hmaster", b + 1), F_HMASTER, 0);
        end
        step();
        set_m0(IDLE, 32'h0, 1'b0, 1'b0, 32'hD000_0003);
        ex("sw_haddr", F_HADDR, 32'h4000_0000);
        ex("sw_hmaster", F_HMASTER, 1);
        ex("sw_hwdata", F_HWDATA, 32'hD000_0003);
        ex("sw_r1", F_R1, 1);
        ex("sw_r0", F_R0, 1);
        step();
        M0_HBURST = 3'd0;
        set_m1(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        ex("park1_hmaster", F_HMASTER, 1);

        // Reset pulse returns ownership to the park master.
        step();
        HRESET = 1'b1;
        ex("rst2_hmaster", F_HMASTER, 0);
        ex("rst2_htrans", F_HTRANS, 32'(IDLE));

        // Both request in the first post-reset cycle: parked M0 wins.
        step();
        HRESET = 1'b0;
        set_m0(NONSEQ, 32'h2000_0010, 1'b0, 1'b0, 32'h0);
        set_m1(NONSEQ, 32'h4000_0010, 1'b0, 1'b0, 32'h0);
        ex("both_hmaster", F_HMASTER, 0);
        ex("both_haddr", F_HADDR, 32'h2000_0010);
        ex("both_r1", F_R1, 0);
        ex("both_r0", F_R0, 1);
        step();
        set_m0(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        ex("both_sw_hmaster", F_HMASTER, 1);
        ex("both_sw_haddr", F_HADDR, 32'h4000_0010);
        ex("both_sw_r1", F_R1, 1);
`ifdef ARB_STATS_EN
        ex("stat_stall1", F_ST1, 1);
`endif

        // M1 locked sequence with M0 pending.
        step();
        set_m1(NONSEQ, 32'h4000_0020, 1'b0, 1'b1, 32'h0);
        set_m0(NONSEQ, 32'h2000_0020, 1'b0, 1'b0, 32'h0);
        ex("lk1_hmaster", F_HMASTER, 1);
        ex("lk1_lock", F_LOCK, 1);
        ex("lk1_r0", F_R0, 0);
        step();
        set_m1(IDLE, 32'h0, 1'b0, 1'b1, 32'h0);
        ex("lk_idle_hmaster", F_HMASTER, 1);
        ex("lk_idle_r0", F_R0, 0);
        ex("lk_idle_htrans", F_HTRANS, 32'(IDLE));
        step();
        set_m1(NONSEQ, 32'h4000_0024, 1'b0, 1'b0, 32'h0);
        ex("lk3_hmaster", F_HMASTER, 1);
        ex("lk3_lock", F_LOCK, 0);
        ex("lk3_r0", F_R0, 0);
        step();
        set_m1(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        ex("lk_rel_hmaster", F_HMASTER, 0);
        ex("lk_rel_haddr", F_HADDR, 32'h2000_0020);
        ex("lk_rel_r0", F_R0, 1);

        // Slave waits on M0's last data phase while M1 is pending.
        step();
        set_m0(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        set_m1(NONSEQ, 32'h4000_0030, 1'b0, 1'b0, 32'h0);
        HREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
            if (w > 0) step();
            ex($sformatf("ws%0d_hmaster", w), F_HMASTER, 1);
            ex($sformatf("ws%0d_r0", w), F_R0, 0);
            ex($sformatf("ws%0d_r1", w), F_R1, 0);
        end
        step();
        HREADY = 1'b1;
        #1;
        chk("ws_expired_r0", {31'd0, M0_HREADY}, 1);
        ex("ws_end_r0", F_R0, 1);
        ex("ws_end_r1", F_R1, 1);
        ex("ws_end_hmaster", F_HMASTER, 1);

        // Two-cycle ERROR on M1's read data phase.
        step();
        set_m1(IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        HRESP = 1'b1;
        HREADY = 1'b0;
        ex("err1_e1", F_E1, 1);
        ex("err1_e0", F_E0, 0);
        ex("err1_r1", F_R1, 0);
        step();
        HREADY = 1'b1;
        ex("err2_e1", F_E1, 1);
        ex("err2_e0", F_E0, 0);
        ex("err2_r1", F_R1, 1);
        step();
        HRESP = 1'b0;
        ex("err_done_e1", F_E1, 0);

        // Reset asserted mid-burst.
        step();
        M1_HBURST = 3'd3;
        set_m1(NONSEQ, 32'h4000_0100, 1'b0, 1'b0, 32'h0);
        ex("mb_hmaster", F_HMASTER, 1);
        step();
        set_m1(SEQ, 32'h4000_0104, 1'b0, 1'b0, 32'h0);
        HRESET = 1'b1;
        ex("mb_rst_hmaster", F_HMASTER, 0);
        ex("mb_rst_htrans", F_HTRANS, 32'(IDLE));
        ex("mb_rst_r1", F_R1, 1);
        step();
        HRESET = 1'b0;
        set_m1(SEQ, 32'h4000_0108, 1'b0, 1'b0, 32'h0);
        ex("mb_post_hmaster", F_HMASTER, 0);
        ex("mb_post_htrans", F_HTRANS, 32'(IDLE));
        ex("mb_post_r1", F_R1, 1);

        step();
        @(negedge HCLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
